// File: rtl/commit_monitor.sv
// Commit monitor: watches the core's register-file (and optionally data-memory) writes and PC,
// declares halt or timeout, and reports done/pass. Optional memory channel: COMMIT_MON_MEM_WATCH_EN.
module commit_monitor #(
  parameter int REG_WIDTH    = 32,
  parameter int REG_COUNT    = 32,
  parameter int NUM_MEM_LOCS = 64,
  parameter int NUM_WATCH    = 4,
  parameter int HALT_CYCLES  = 4,
  parameter int TIMEOUT      = 1024,
  localparam int RA = $clog2(REG_COUNT),
  localparam int MA = $clog2(NUM_MEM_LOCS)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [REG_WIDTH-1:0]           pc,
  input  logic                           rf_we,
  input  logic [RA-1:0]                  rf_waddr,
  input  logic [REG_WIDTH-1:0]           rf_wdata,
  input  logic [NUM_WATCH*RA-1:0]        watch_addr,
  input  logic [NUM_WATCH*REG_WIDTH-1:0] watch_exp,
  output logic [NUM_WATCH*REG_WIDTH-1:0] watch_val,
`ifdef COMMIT_MON_MEM_WATCH_EN
  input  logic                           mem_we,
  input  logic [MA-1:0]                  mem_addr,
  input  logic [REG_WIDTH-1:0]           mem_wdata,
  input  logic [MA-1:0]                  mem_watch_addr,
  input  logic [REG_WIDTH-1:0]           mem_watch_exp,
  output logic [REG_WIDTH-1:0]           mem_watch_val,
`endif
  output logic [1:0]                     state,
  output logic [31:0]                    cycles,
  output logic                           done,
  output logic                           pass
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int SW = $clog2(HALT_CYCLES);
  localparam logic [SW-1:0] STABLE_MAX   = SW'(HALT_CYCLES - 1);
  localparam logic [SW-1:0] HALT_MATCH   = SW'(HALT_CYCLES - 2);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_e                         state_q, state_d;
  logic [REG_WIDTH-1:0]           pc_prev_q, pc_prev_d;
  logic [SW-1:0]                  stable_q, stable_d;
  logic [31:0]                    cycles_q, cycles_d;
  logic [NUM_WATCH*REG_WIDTH-1:0] watch_q, watch_d;
  logic                           halt_s;
  logic                           rf_hit_s;
  logic                           mem_ok_s;
`ifdef COMMIT_MON_MEM_WATCH_EN
  logic [REG_WIDTH-1:0]           mem_q, mem_d;
`endif

  // PC counts as stable once it has been sampled identical HALT_CYCLES times in a row
  assign halt_s   = (state_q == ST_RUN) && (pc == pc_prev_q) && (stable_q == HALT_MATCH);
  assign rf_hit_s = rf_we && (rf_waddr != {RA{1'b0}});

  // Next-state: FSM, halt detector, cycle counter and capture channels
  always_comb begin
    state_d   = state_q;
    pc_prev_d = pc_prev_q;
    stable_d  = stable_q;
    cycles_d  = cycles_q;
    watch_d   = watch_q;
`ifdef COMMIT_MON_MEM_WATCH_EN
    mem_d     = mem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cycles_d  = cycles_q + 32'd1;
        pc_prev_d = pc;
        if (pc != pc_prev_q) begin
          stable_d = {SW{1'b0}};
        end else if (stable_q != STABLE_MAX) begin
          stable_d = stable_q + {{(SW-1){1'b0}}, 1'b1};
        end else begin
          stable_d = stable_q;
        end
        // Halt wins over a timeout landing on the same edge
        if (halt_s) begin
          state_d = ST_HALTED;
        end else if (cycles_q == TIMEOUT_LAST) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
        for (int i = 0; i < NUM_WATCH; i++) begin
          if (rf_hit_s && (watch_addr[i*RA +: RA] == rf_waddr)) begin
            watch_d[i*REG_WIDTH +: REG_WIDTH] = rf_wdata;
          end else begin
            watch_d[i*REG_WIDTH +: REG_WIDTH] = watch_q[i*REG_WIDTH +: REG_WIDTH];
          end
        end
`ifdef COMMIT_MON_MEM_WATCH_EN
        if (mem_we && (mem_addr == mem_watch_addr)) begin
          mem_d = mem_wdata;
        end else begin
          mem_d = mem_q;
        end
`endif
      end
      ST_HALTED, ST_TIMEOUT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      pc_prev_q <= {REG_WIDTH{1'b1}};
      stable_q  <= {SW{1'b0}};
      cycles_q  <= 32'd0;
      watch_q   <= {(NUM_WATCH*REG_WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      pc_prev_q <= pc_prev_d;
      stable_q  <= stable_d;
      cycles_q  <= cycles_d;
      watch_q   <= watch_d;
    end
  end

`ifdef COMMIT_MON_MEM_WATCH_EN
  // Memory watch register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= {REG_WIDTH{1'b0}};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign mem_ok_s      = (mem_q == mem_watch_exp);
  assign mem_watch_val = mem_q;
`else
  assign mem_ok_s = 1'b1;
`endif

  assign state     = state_q;
  assign cycles    = cycles_q;
  assign watch_val = watch_q;
  assign done      = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
  assign pass      = (state_q == ST_HALTED) && (watch_q == watch_exp) && mem_ok_s;

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Parametrised, synthesizable commit monitor that sits beside `riscv_single_cycle_processor` and observes its register-file write port, PC and (optionally) data-memory write port. It tracks `NUM_WATCH` architectural registers, detects program halt (PC self-loop) or timeout, and reports a registered done/pass verdict. It replaces hand-probed signals such as `x5`, `x6` and `mem1` with a configurable, self-checking block usable in both simulation and on-board bring-up.

## Interface
- `REG_WIDTH`, 32: data and PC width.
- `REG_COUNT`, 32: architectural registers. `RA = $clog2(REG_COUNT)`.
- `NUM_MEM_LOCS`, 64: data-memory words. `MA = $clog2(NUM_MEM_LOCS)`.
- `NUM_WATCH`, 4: watched-register channels, minimum 1.
- `HALT_CYCLES`, 4: consecutive cycles of unchanged PC that declare a halt, minimum 2.
- `TIMEOUT`, 1024: maximum RUN cycles before the block gives up.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous, active-low reset.
- `pc` in `REG_WIDTH`: current PC.
- `rf_we` in 1: register-file write enable.
- `rf_waddr` in `RA`: register-file write address.
- `rf_wdata` in `REG_WIDTH`: register-file write data.
- `watch_addr` in `NUM_WATCH*RA`: channel i register index, in slice i.
- `watch_exp` in `NUM_WATCH*REG_WIDTH`: channel i expected value.
- `watch_val` out `NUM_WATCH*REG_WIDTH`: channel i last captured value.
- `mem_we` in 1, `mem_addr` in `MA`, `mem_wdata` in `REG_WIDTH`: data-memory write port. Present only with the macro.
- `mem_watch_addr` in `MA`, `mem_watch_exp` in `REG_WIDTH`, `mem_watch_val` out `REG_WIDTH`: present only with the macro.
- `state` out 2: 0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT.
- `cycles` out 32: RUN cycle count.
- `done` out 1, `pass` out 1: verdict.

## Operation
- FSM transitions:
  - IDLE → RUN on the first clock edge after `rstn` deasserts.
  - RUN → HALTED when the halt condition holds.
  - Otherwise RUN → TIMEOUT when `cycles == TIMEOUT-1`.
  - HALTED and TIMEOUT are terminal until reset.
  - If halt and timeout occur in the same cycle, HALTED wins.
- Halt detect:
  - `pc_prev` register, reset value all-ones. `stable_cnt` register, reset value 0, saturating.
  - In RUN: if `pc == pc_prev`, `stable_cnt` increments; else `stable_cnt` clears. `pc_prev <= pc` every RUN cycle.
  - Halt condition: `pc == pc_prev && stable_cnt == HALT_CYCLES-2`. This means PC has been sampled identical for `HALT_CYCLES` consecutive cycles.
- Capture, RUN only:
  - When `rf_we` is high and `rf_waddr != 0`, every channel with `watch_addr[i] == rf_waddr` loads `rf_wdata`.
  - Several channels may watch the same register; all of them update.
  - Writes to x0 are ignored. A channel watching x0 stays 0.
  - Writes in IDLE, HALTED or TIMEOUT are ignored.
- `cycles` increments once per RUN cycle, is 32-bit wrapping, and freezes in terminal states.
- `done = (state == HALTED || state == TIMEOUT)`, decoded from the state register.
- `pass = (state == HALTED) && all watch_val[i] == watch_exp[i]` (plus the memory channel when compiled in).
  - Combinational from registers and the `watch_exp` inputs.
  - `pass` is always 0 in TIMEOUT.
- `watch_addr` and `watch_exp` are expected to be static during RUN. Changing `watch_addr` mid-run only affects subsequent captures.

## Timing
- Reset values:
  - `state` = IDLE.
  - All `watch_val` = 0, `mem_watch_val` = 0.
  - `cycles` = 0, `done` = 0, `pass` = 0.
  - `pc_prev` = all-ones, `stable_cnt` = 0.
- Asserting `rstn` low mid-run clears everything immediately (asynchronously). The first RUN cycle follows one edge after release.
- Capture latency is 1 cycle: a write sampled at edge N is visible on `watch_val` after edge N.
- The RUN→HALTED edge also captures a write in that same cycle; the final write counts toward `pass`.
- `done` rises one cycle after the halt condition is sampled.
- A timeout gives `done=1`, `state=3` exactly after `TIMEOUT` RUN cycles.

## Configuration
- `COMMIT_MON_MEM_WATCH_EN` defined:
  - Memory ports exist.
  - When `mem_we && mem_addr == mem_watch_addr` in RUN, `mem_watch_val` loads `mem_wdata` with 1-cycle latency.
  - `pass` additionally requires `mem_watch_val == mem_watch_exp`.
- Undefined: memory ports and logic are absent, and `pass` depends on register channels only.

## Test plan
- Reset and launch:
  - Hold `rstn`=0 for 3 cycles → `state`=0, all outputs 0.
  - Release `rstn` → `state`=1 after the next edge; `cycles` counts 1, 2, 3….
- Capture with x0 rejection:
  - `watch_addr`={x5, x6, x5, x0}.
  - Write x5=10, then x6=20, then x0=99 → `watch_val`={10, 20, 10, 0}, each one cycle after its write.
- Halt and pass:
  - `HALT_CYCLES`=4, expected {10, 20, 10, 0}, `pc` steps 0, 4, 8, then holds 8.
  - → `done`=1, `pass`=1, `state`=2 one cycle after the 4th sampled 8; `cycles` frozen.
- Halt and fail:
  - Same stimulus with `watch_exp[1]`=21 → `done`=1, `pass`=0, `state`=2.
- Timeout:
  - `TIMEOUT`=16, `pc` incrementing by 4 every cycle → `state`=3, `done`=1, `pass`=0, `cycles`=16.
- Reset mid-run and memory watch:
  - Drop `rstn` while in RUN → immediate clear.
  - With `COMMIT_MON_MEM_WATCH_EN`: store 7 to address 1 with `mem_watch_addr`=1, `mem_watch_exp`=7, then halt → `mem_watch_val`=7, `pass`=1.
